// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges two ALU pipes and a FIFO-buffered LSU onto two register-file write ports with WAW kill.
// Optional build macro WB_STATS_EN adds the stat_lsu_stall / stat_waw_kill counters.
`default_nettype none

module writeback_arbiter #(
  parameter int XLEN          = 32,
  parameter int LSU_BUF_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             alu0_valid,
  input  logic [4:0]                       alu0_rd,
  input  logic [XLEN-1:0]                  alu0_data,
  input  logic                             alu1_valid,
  input  logic [4:0]                       alu1_rd,
  input  logic [XLEN-1:0]                  alu1_data,
  input  logic                             lsu_valid,
  output logic                             lsu_ready,
  input  logic [4:0]                       lsu_rd,
  input  logic [XLEN-1:0]                  lsu_data,
  output logic                             wr_en_0,
  output logic [4:0]                       rd_addr_0,
  output logic [XLEN-1:0]                  rd_data_0,
  output logic                             wr_en_1,
  output logic [4:0]                       rd_addr_1,
  output logic [XLEN-1:0]                  rd_data_1,
  output logic [$clog2(LSU_BUF_DEPTH):0]   wb_pending
`ifdef WB_STATS_EN
  ,
  output logic [31:0]                      stat_lsu_stall,
  output logic [31:0]                      stat_waw_kill
`endif
);

  localparam int AW = $clog2(LSU_BUF_DEPTH);

  logic [4:0]               buf_rd   [LSU_BUF_DEPTH];
  logic [XLEN-1:0]          buf_data [LSU_BUF_DEPTH];
  logic [LSU_BUF_DEPTH-1:0] buf_live;
  logic [AW-1:0]            head, tail;
  logic [AW:0]              count;

  logic                     alu0_eff, alu1_eff, push, pop, kill_in;
  logic                     head_live, head_wr;
  logic [LSU_BUF_DEPTH-1:0] kill_vec;
  logic                     n_en0, n_en1;
  logic [4:0]               n_rd0, n_rd1;
  logic [XLEN-1:0]          n_d0, n_d1;

  assign lsu_ready  = (count != (AW+1)'(LSU_BUF_DEPTH));
  assign wb_pending = count;
  assign push       = lsu_valid && lsu_ready;

  always_comb begin
    alu0_eff = alu0_valid && (alu0_rd != 5'd0) && !(alu1_valid && (alu1_rd == alu0_rd));
    alu1_eff = alu1_valid && (alu1_rd != 5'd0);
    kill_in  = push && ((alu0_eff && (lsu_rd == alu0_rd)) || (alu1_eff && (lsu_rd == alu1_rd)));
    kill_vec = '0;
    for (int i = 0; i < LSU_BUF_DEPTH; i++) begin
      // Only occupied, still-live slots count as killed
      kill_vec[i] = buf_live[i]
                 && ({1'b0, AW'(AW'(i) - head)} < count)
                 && ((alu0_eff && (buf_rd[i] == alu0_rd)) || (alu1_eff && (buf_rd[i] == alu1_rd)));
    end
    head_live = (count != '0) && buf_live[head] && (buf_rd[head] != 5'd0) && !kill_vec[head];
    head_wr   = head_live && !(alu0_eff && alu1_eff);
    pop       = (count != '0) && (head_wr || !head_live);
  end

  // Candidate order: ALU0, ALU1, FIFO head
  always_comb begin
    n_en0 = 1'b0; n_rd0 = 5'd0; n_d0 = '0;
    n_en1 = 1'b0; n_rd1 = 5'd0; n_d1 = '0;
    if (alu0_eff) begin
      n_en0 = 1'b1; n_rd0 = alu0_rd; n_d0 = alu0_data;
      if (alu1_eff) begin
        n_en1 = 1'b1; n_rd1 = alu1_rd; n_d1 = alu1_data;
      end else if (head_wr) begin
        n_en1 = 1'b1; n_rd1 = buf_rd[head]; n_d1 = buf_data[head];
      end
    end else if (alu1_eff) begin
      n_en0 = 1'b1; n_rd0 = alu1_rd; n_d0 = alu1_data;
      if (head_wr) begin
        n_en1 = 1'b1; n_rd1 = buf_rd[head]; n_d1 = buf_data[head];
      end
    end else if (head_wr) begin
      n_en0 = 1'b1; n_rd0 = buf_rd[head]; n_d0 = buf_data[head];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_rd[tail]   <= lsu_rd;
      buf_data[tail] <= lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      buf_live  <= '0;
      wr_en_0   <= 1'b0;
      rd_addr_0 <= 5'd0;
      rd_data_0 <= '0;
      wr_en_1   <= 1'b0;
      rd_addr_1 <= 5'd0;
      rd_data_1 <= '0;
    end else begin
      buf_live <= buf_live & ~kill_vec;
      if (push) begin
        buf_live[tail] <= !kill_in;
        tail           <= tail + AW'(1);
      end
      if (pop) head <= head + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (!push && pop) count <= count - (AW+1)'(1);
      wr_en_0   <= n_en0;
      rd_addr_0 <= n_rd0;
      rd_data_0 <= n_d0;
      wr_en_1   <= n_en1;
      rd_addr_1 <= n_rd1;
      rd_data_1 <= n_d1;
    end
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_lsu_stall <= '0;
      stat_waw_kill  <= '0;
    end else begin
      if (lsu_valid && !lsu_ready) stat_lsu_stall <= stat_lsu_stall + 32'd1;
      if ((|kill_vec) || kill_in)  stat_waw_kill  <= stat_waw_kill + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// Directed scoreboard bench for writeback_arbiter (XLEN=32, LSU_BUF_DEPTH=4).
`default_nettype none

module tb_writeback_arbiter;

  localparam int XLEN = 32;
  localparam int D    = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu0_valid, alu1_valid, lsu_valid;
  logic [4:0]      alu0_rd, alu1_rd, lsu_rd;
  logic [XLEN-1:0] alu0_data, alu1_data, lsu_data;
  logic            lsu_ready, wr_en_0, wr_en_1;
  logic [4:0]      rd_addr_0, rd_addr_1;
  logic [XLEN-1:0] rd_data_0, rd_data_1;
  logic [2:0]      wb_pending;
`ifdef WB_STATS_EN
  logic [31:0]     stat_lsu_stall, stat_waw_kill;
`endif

  writeback_arbiter #(.XLEN(XLEN), .LSU_BUF_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu0_valid(alu0_valid), .alu0_rd(alu0_rd), .alu0_data(alu0_data),
    .alu1_valid(alu1_valid), .alu1_rd(alu1_rd), .alu1_data(alu1_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wr_en_0(wr_en_0), .rd_addr_0(rd_addr_0), .rd_data_0(rd_data_0),
    .wr_en_1(wr_en_1), .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1),
    .wb_pending(wb_pending)
`ifdef WB_STATS_EN
    , .stat_lsu_stall(stat_lsu_stall), .stat_waw_kill(stat_waw_kill)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        e0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        e1;
    logic [4:0]  a1;
    logic [31:0] d1;
  } exp_t;

  exp_t q[$];
  int   cycle = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic sb_push(input int lat, input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic e1, input logic [4:0] a1, input logic [31:0] d1);
    exp_t x;
    x.cyc = cycle + lat;
    x.e0 = e0; x.a0 = a0; x.d0 = d0;
    x.e1 = e1; x.a1 = a1; x.d1 = d1;
    q.push_back(x);
  endtask

  task automatic sb_idle();
    sb_push(1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    exp_t x;
    @(posedge clk);
    #1;
    cycle++;
    while (q.size() > 0 && q[0].cyc <= cycle) begin
      x = q.pop_front();
      chk("wr_en_0", {31'd0, wr_en_0}, {31'd0, x.e0});
      if (x.e0) begin
        chk("rd_addr_0", {27'd0, rd_addr_0}, {27'd0, x.a0});
        chk("rd_data_0", rd_data_0, x.d0);
      end
      chk("wr_en_1", {31'd0, wr_en_1}, {31'd0, x.e1});
      if (x.e1) begin
        chk("rd_addr_1", {27'd0, rd_addr_1}, {27'd0, x.a1});
        chk("rd_data_1", rd_data_1, x.d1);
      end
    end
  endtask

  task automatic drv(input logic a0v, input logic [4:0] a0r, input logic [31:0] a0d,
                     input logic a1v, input logic [4:0] a1r, input logic [31:0] a1d,
                     input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    alu0_valid = a0v; alu0_rd = a0r; alu0_data = a0d;
    alu1_valid = a1v; alu1_rd = a1r; alu1_data = a1d;
    lsu_valid  = lv;  lsu_rd  = lr;  lsu_data  = ld;
  endtask

  task automatic drv_idle();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int   acc;
    logic rdy_exp;

    drv_idle();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_wr_en_0", {31'd0, wr_en_0}, 32'd0);
    chk("rst_wr_en_1", {31'd0, wr_en_1}, 32'd0);
    chk("rst_rd_addr_0", {27'd0, rd_addr_0}, 32'd0);
    chk("rst_rd_addr_1", {27'd0, rd_addr_1}, 32'd0);
    chk("rst_rd_data_0", rd_data_0, 32'd0);
    chk("rst_rd_data_1", rd_data_1, 32'd0);
    chk("rst_pending", {29'd0, wb_pending}, 32'd0);
    chk("rst_ready", {31'd0, lsu_ready}, 32'd1);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", {31'd0, lsu_ready}, 32'd1);
    chk("post_rst_pending", {29'd0, wb_pending}, 32'd0);

    // Two ALU writes to distinct registers
    drv(1'b1, 5'd3, 32'hAAAA_0001, 1'b1, 5'd7, 32'hBBBB_0002, 1'b0, 5'd0, 32'd0);
    sb_push(1, 1'b1, 5'd3, 32'hAAAA_0001, 1'b1, 5'd7, 32'hBBBB_0002);
    tick();

    // Same rd on both ALUs: only the younger survives, on port 0
    drv(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 32'd0);
    sb_push(1, 1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 32'd0);
    tick();
    drv_idle();
    sb_idle();
    tick();

    // LSU push, write two cycles later
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hAA);
    chk("lsu_ready_single", {31'd0, lsu_ready}, 32'd1);
    sb_idle();
    tick();
    chk("pending_after_push", {29'd0, wb_pending}, 32'd1);
    drv_idle();
    sb_push(1, 1'b1, 5'd9, 32'hAA, 1'b0, 5'd0, 32'd0);
    tick();
    chk("pending_after_pop", {29'd0, wb_pending}, 32'd0);
    sb_idle();
    tick();

    // WAW kill of a buffered LSU entry by ALU1
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h1);
    sb_idle();
    tick();
    drv(1'b1, 5'd10, 32'h33, 1'b1, 5'd4, 32'h2, 1'b0, 5'd0, 32'd0);
    sb_push(1, 1'b1, 5'd10, 32'h33, 1'b1, 5'd4, 32'h2);
    tick();
    chk("pending_after_kill", {29'd0, wb_pending}, 32'd0);
`ifdef WB_STATS_EN
    chk("stat_waw_kill", stat_waw_kill, 32'd1);
`endif
    drv_idle();
    repeat (3) begin
      sb_idle();
      tick();
    end

    // ALUs saturate both ports while the LSU fills the FIFO
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      drv(1'b1, 5'd20, 32'h5000 + k, 1'b1, 5'd21, 32'h6000 + k,
          1'b1, 5'(11 + acc), 32'h100 + acc);
      rdy_exp = (acc < D);
      chk("lsu_ready_fill", {31'd0, lsu_ready}, {31'd0, rdy_exp});
      sb_push(1, 1'b1, 5'd20, 32'h5000 + k, 1'b1, 5'd21, 32'h6000 + k);
      tick();
      if (rdy_exp) acc++;
    end
    chk("pending_full", {29'd0, wb_pending}, 32'd4);
    chk("lsu_ready_full", {31'd0, lsu_ready}, 32'd0);
`ifdef WB_STATS_EN
    chk("stat_lsu_stall", stat_lsu_stall, 32'd2);
`endif
    drv_idle();
    for (int i = 0; i < D; i++)
      sb_push(i + 1, 1'b1, 5'(11 + i), 32'h100 + i, 1'b0, 5'd0, 32'd0);
    sb_push(D + 1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i <= D; i++) begin
      tick();
      chk("pending_drain", {29'd0, wb_pending}, (i < D) ? 32'(D - 1 - i) : 32'd0);
    end

    // Mid-operation reset discards buffered entries
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 5'd22, 32'h7000 + k, 1'b1, 5'd23, 32'h8000 + k,
          1'b1, 5'(24 + k), 32'h700 + k);
      sb_push(1, 1'b1, 5'd22, 32'h7000 + k, 1'b1, 5'd23, 32'h8000 + k);
      tick();
    end
    chk("pending_before_rst", {29'd0, wb_pending}, 32'd3);
    drv_idle();
    rst_n = 1'b0;
    sb_idle();
    tick();
    rst_n = 1'b1;
    chk("mid_rst_pending", {29'd0, wb_pending}, 32'd0);
    chk("mid_rst_ready", {31'd0, lsu_ready}, 32'd1);
    chk("mid_rst_rd_addr_0", {27'd0, rd_addr_0}, 32'd0);
`ifdef WB_STATS_EN
    chk("mid_rst_stat_stall", stat_lsu_stall, 32'd0);
    chk("mid_rst_stat_kill", stat_waw_kill, 32'd0);
`endif
    repeat (5) begin
      sb_idle();
      tick();
    end
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
